q_update: RTL
=============

# q_update

Q-table write-back unit for the tic-tac-toe learning agent: it is the writer side of the Q-table whose rows the action-selection policy reads. On each `start` it reads Q(s,a) from the Q-table memory and computes the Q-learning update from the reward and the next-state maximum Q. It then writes the new value back to the same address. It sits between the max-Q/policy path, the environment reward logic and the shared Q-table RAM port.

## Interface

Parameters:
- STATE_W, 15, board-state index width (3^9 = 19683 states).
- ADDR_W, 18, Q-table address width; must hold 19683*9-1.
- ALPHA_SHIFT, 2, learning rate alpha = 2^-ALPHA_SHIFT.
- GAMMA_SHIFT, 3, discount gamma = 1 - 2^-GAMMA_SHIFT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- state_idx  in  STATE_W  current board state s.
- action  in  4  action a taken, valid range 0..8.
- reward  in  18  signed Q7.10 reward r.
- q_next_max  in  18  signed Q7.10 max Q(s',·) from the max-Q unit.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse after the write completes.
- err  out  1  one-cycle pulse for an invalid action.
- mem_addr  out  ADDR_W  Q-table address.
- mem_rd_en  out  1  read strobe; mem_rdata is valid the following cycle.
- mem_rdata  in  18  signed Q7.10 read data.
- mem_wr_en  out  1  write strobe.
- mem_wdata  out  18  signed Q7.10 write data.

## Operation

- All Q values are 18-bit signed Q7.10 (1.0 = 1024).
- FSM states: IDLE, READ, WAIT, CALC, WRITE, DONE.
- **IDLE**
  - On start=1 with action<=8: latch state_idx, action, reward and q_next_max, then go to READ.
  - On start=1 with action>8: pulse err the next cycle, stay in IDLE, make no memory access.
- **READ**
  - mem_addr = state_idx*9 + action, computed on latched values with ADDR_W-bit unsigned arithmetic.
  - mem_rd_en=1.
- **WAIT**: capture mem_rdata into q_old at the end of the cycle.
- **CALC**: all arithmetic is sign-extended to 20 bits, and shifts are arithmetic.
  - target = r + q_next_max - (q_next_max >>> GAMMA_SHIFT)
  - delta = target - q_old
  - q_new = q_old + (delta >>> ALPHA_SHIFT)
  - Register q_new, reduced to 18 bits according to Configuration.
- **WRITE**: mem_addr holds the same address, mem_wr_en=1, mem_wdata = q_new.
- **DONE**: done=1, busy=0 in this cycle, then return to IDLE.
- start while busy is ignored and is not queued.
- mem_rd_en and mem_wr_en are never high in the same cycle.

## Timing

- Reset values: busy=0, done=0, err=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0; FSM in IDLE.
- All outputs are registered.
- Accepted start in cycle T:
  - mem_rd_en in T+1;
  - mem_rdata sampled at the end of T+2;
  - mem_wr_en in T+4;
  - done in T+5.
- busy is high T+1..T+4.
- A new start is accepted in T+5, the DONE cycle, with its READ in T+6.
- Reset asserted mid-operation clears the FSM immediately. No write strobe issues after reset assertion, and a partial update is discarded.
- An invalid action at T gives err=1 in T+1, with busy=0 and done=0 throughout.

## Configuration

- `Q_UPDATE_SAT_EN` defined: q_new is clamped to [-131072, 131071] before the write.
- Undefined: q_new is truncated to its low 18 bits and wraps in two's complement. This saves the comparators.

## Test plan

- Reset then idle: outputs all zero. Then state=0, action=0, Q=0, r=1024, q_next_max=0 -> mem_wdata=256, mem_addr=0, done at T+5.
- state=5, action=8 -> mem_addr=53. With q_old=512, r=0, q_next_max=1024 -> target 896, delta 384, mem_wdata=608.
- Negative update: q_old=0, r=-1024, q_next_max=0 -> mem_wdata=-256 (0x3FF00).
- Overflow: q_old=r=q_next_max=131071.
  - With `Q_UPDATE_SAT_EN`: mem_wdata=131071.
  - Without it: wraps to -102401.
- action=9 -> err pulse at T+1, no mem_rd_en or mem_wr_en, busy stays 0. start asserted while busy -> ignored, exactly one write.
- rst driven low during WAIT -> mem_wr_en never asserts and all outputs go to their reset values. After release, a new start completes normally.

Source files
------------

// File: rtl/q_update.sv
// Q-table write-back unit: read Q(s,a), apply the Q-learning update, write it back.
// Define Q_UPDATE_SAT_EN to clamp the new value instead of wrapping it.
module q_update #(
   parameter int STATE_W     = 15,
   parameter int ADDR_W      = 18,
   parameter int ALPHA_SHIFT = 2,
   parameter int GAMMA_SHIFT = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [STATE_W-1:0] state_idx,
   input  logic [3:0]         action,
   input  logic [17:0]        reward,
   input  logic [17:0]        q_next_max,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_rd_en,
   input  logic [17:0]        mem_rdata,
   output logic               mem_wr_en,
   output logic [17:0]        mem_wdata
);

   // state   | meaning
   // S_IDLE  | waiting for start
   // S_READ  | read strobe on the Q-table port
   // S_WAIT  | read data arrives, captured into q_old
   // S_CALC  | update computed and registered as write data
   // S_WRITE | write strobe on the same address
   // S_DONE  | done pulse; a new start is accepted here as in IDLE
   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_CALC, S_WRITE, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                rd_en_q, rd_en_d;
   logic                wr_en_q, wr_en_d;
   logic [17:0]         wdata_q, wdata_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [17:0]         reward_q, reward_d;
   logic [17:0]         qnm_q, qnm_d;
   logic [17:0]         q_old_q, q_old_d;

   logic signed [19:0]  r_ext, qn_ext, qo_ext;
   logic signed [19:0]  target, delta, q_new_w;
   logic [17:0]         q_new;

   always_comb begin
      r_ext   = {{2{reward_q[17]}}, reward_q};
      qn_ext  = {{2{qnm_q[17]}}, qnm_q};
      qo_ext  = {{2{q_old_q[17]}}, q_old_q};
      target  = r_ext + qn_ext - (qn_ext >>> GAMMA_SHIFT);
      delta   = target - qo_ext;
      q_new_w = qo_ext + (delta >>> ALPHA_SHIFT);
`ifdef Q_UPDATE_SAT_EN
      if (q_new_w > 20'sd131071)
         q_new = 18'h1FFFF;
      else if (q_new_w < -20'sd131072)
         q_new = 18'h20000;
      else
         q_new = 18'(q_new_w);
`else
      q_new = 18'(q_new_w);
`endif
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rd_en_d  = 1'b0;
      wr_en_d  = 1'b0;
      wdata_d  = wdata_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      reward_d = reward_q;
      qnm_d    = qnm_q;
      q_old_d  = q_old_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            if (start) begin
               if (action <= 4'd8) begin
                  state_d  = S_READ;
                  addr_d   = ADDR_W'(state_idx) * ADDR_W'(9) + ADDR_W'(action);
                  rd_en_d  = 1'b1;
                  busy_d   = 1'b1;
                  reward_d = reward;
                  qnm_d    = q_next_max;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_READ: state_d = S_WAIT;
         S_WAIT: begin
            q_old_d = mem_rdata;
            state_d = S_CALC;
         end
         S_CALC: begin
            wdata_d = q_new;
            wr_en_d = 1'b1;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         rd_en_q  <= 1'b0;
         wr_en_q  <= 1'b0;
         wdata_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         reward_q <= '0;
         qnm_q    <= '0;
         q_old_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rd_en_q  <= rd_en_d;
         wr_en_q  <= wr_en_d;
         wdata_q  <= wdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         reward_q <= reward_d;
         qnm_q    <= qnm_d;
         q_old_q  <= q_old_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign mem_addr  = addr_q;
   assign mem_rd_en = rd_en_q;
   assign mem_wr_en = wr_en_q;
   assign mem_wdata = wdata_q;

endmodule
